// File: rtl/ctl_pipe.sv
// ctl_pipe: pipelined control unit for the SIMPLE core.
// Decodes one 16-bit instruction per cycle into a 23-bit control bundle and
// carries it through STAGES bundle registers (stage 0 = ID/EX). Handles
// stall/flush bubbles, a halt-drain FSM and a retired-instruction counter.
module ctl_pipe #(
    parameter int unsigned STAGES = 3,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inst_valid,
    input  logic [15:0]            inst,
    input  logic                   stall,
    input  logic                   flush,
    output logic [STAGES*23-1:0]   ctl_bus,
    output logic                   fetch_en,
    output logic                   halted,
    output logic [CNT_W-1:0]       retired_cnt
);

    localparam int unsigned BW     = 23;
    localparam int unsigned LAST   = STAGES - 1;
    localparam int unsigned B_VLD  = 22;
    localparam int unsigned B_HALT = 21;

    // Bubble: everything cleared except branch = 3'b111 (no branch)
    localparam logic [BW-1:0] BUBBLE = 23'h000380;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t                    state_q, state_d;
    logic [STAGES-1:0][BW-1:0] stage_q, stage_d;
    logic                      halted_q, halted_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    logic [1:0]                dec_t;
    logic [3:0]                dec_op;
    logic [2:0]                dec_b;
    logic                      dec_is_r;
    logic                      dec_halt;
    logic                      dec_as_bc;
    logic                      dec_alu_or_shift;
    logic                      dec_is_in;
    logic                      dec_is_out;
    logic                      dec_alusrc2;
    logic                      dec_alusrc1;
    logic                      dec_memtoreg;
    logic                      dec_regwrite;
    logic                      dec_memwrite;
    logic                      dec_memread;
    logic                      dec_branch_cond;
    logic [2:0]                dec_branch;
    logic [3:0]                dec_opcode;
    logic [2:0]                dec_reg_dst;
    logic [BW-1:0]             dec_bundle;
    logic                      any_halt_d;
    logic                      retire;

    // Immediate field carries no control information
    logic                      unused_inst_low;
    assign unused_inst_low = ^inst[3:0];

    // Instruction decode into a control bundle
    always_comb begin
        dec_t            = inst[15:14];
        dec_op           = inst[7:4];
        dec_b            = inst[13:11];
        dec_is_r         = (dec_t == 2'b11);

        dec_regwrite     = (dec_is_r && !(dec_op == 4'b0101 || dec_op == 4'b0111 || dec_op >= 4'b1100))
                         || (dec_t == 2'b00)
                         || (dec_t == 2'b10 && dec_b == 3'b000);
        dec_memwrite     = (dec_t == 2'b01);
        dec_memread      = (dec_t == 2'b00);
        dec_memtoreg     = (dec_t == 2'b00) || (dec_is_r && dec_op == 4'b1100);
        dec_alusrc1      = (dec_t == 2'b10) && (dec_b != 3'b000);
        dec_alusrc2      = !(dec_is_r && dec_op <= 4'b0110);
        dec_is_out       = dec_is_r && (dec_op == 4'b1101);
        dec_is_in        = dec_is_r && (dec_op == 4'b1100);
        dec_alu_or_shift = dec_is_r && (dec_op[3:2] == 2'b10);
        dec_halt         = dec_is_r && (dec_op == 4'b1111);
        dec_as_bc        = dec_is_r && !(dec_op == 4'b0111 || dec_op >= 4'b1100);

        if (dec_is_r) begin
            dec_opcode = dec_op;
        end else if (dec_t == 2'b10 && dec_b == 3'b000) begin
            dec_opcode = 4'b0110;
        end else begin
            dec_opcode = 4'b0000;
        end

        if (dec_t == 2'b10 && dec_b == 3'b111) begin
            dec_branch      = inst[10:8];
            dec_branch_cond = 1'b1;
        end else if (dec_t == 2'b10 && dec_b == 3'b100) begin
            dec_branch      = 3'b100;
            dec_branch_cond = 1'b1;
        end else begin
            dec_branch      = 3'b111;
            dec_branch_cond = 1'b0;
        end

        dec_reg_dst = (dec_t == 2'b00) ? inst[13:11] : inst[10:8];

        dec_bundle = {1'b1, dec_halt, dec_as_bc, dec_alu_or_shift, dec_is_in, dec_is_out,
                      dec_alusrc2, dec_alusrc1, dec_memtoreg, dec_regwrite, dec_memwrite,
                      dec_memread, dec_branch_cond, dec_branch, dec_opcode, dec_reg_dst};
    end

    // Next contents of every bundle stage: bubble insertion, hold and shift
    always_comb begin
        stage_d = stage_q;

        if (state_q == ST_HALTED) begin
            stage_d[0] = BUBBLE;
        end else if (flush) begin
            stage_d[0] = BUBBLE;
        end else if (stall) begin
            stage_d[0] = stage_q[0];
        end else if (state_q != ST_RUN || !inst_valid) begin
            stage_d[0] = BUBBLE;
        end else begin
            stage_d[0] = dec_bundle;
        end

        for (int unsigned s = 1; s < STAGES; s++) begin
            if (state_q == ST_HALTED) begin
                stage_d[s] = BUBBLE;
            end else if (s == 32'd1 && (flush || stall)) begin
                stage_d[s] = BUBBLE;
            end else begin
                stage_d[s] = stage_q[s-1];
            end
        end

        any_halt_d = 1'b0;
        for (int unsigned s = 0; s < STAGES; s++) begin
            any_halt_d = any_halt_d | stage_d[s][B_HALT];
        end
    end

    // Halt-drain FSM, retired counter and fetch enable
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (stage_d[0][B_HALT]) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Retiring the halt wins over the "no halt left" test, which
                // would otherwise also be true on the very same edge.
                if (stage_q[LAST][B_HALT]) begin
                    state_d = ST_HALTED;
                end else if (!any_halt_d) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        halted_d = (state_d == ST_HALTED);
        retire   = stage_q[LAST][B_VLD];
        cnt_d    = cnt_q + CNT_W'(retire);
        fetch_en = (state_q == ST_RUN) && !stall && !flush && !(dec_halt && inst_valid);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q  <= {STAGES{BUBBLE}};
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stage_q  <= stage_d;
            state_q  <= state_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ctl_bus     = stage_q;
    assign halted      = halted_q;
    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_ctl_pipe.sv
// Directed testbench for ctl_pipe: decode vectors, latency, stall, flush,
// halt drain, halt cancel by flush, counter wrap and reset.
module tb_ctl_pipe;

    localparam logic [22:0] BUB = 23'h000380;
    localparam logic [22:0] ADD = 23'h502381;
    localparam logic [22:0] LD  = 23'h416B82;
    localparam logic [22:0] BR  = 23'h418600;
    localparam logic [22:0] HLT = 23'h6103F8;

    logic        clk;
    logic        rst_n;
    logic        inst_valid;
    logic [15:0] inst;
    logic        stall;
    logic        flush;
    logic [68:0] bus;
    logic        fetch_en;
    logic        halted;
    logic [15:0] cnt;
    logic [68:0] w4_bus;
    logic        w4_fetch_en;
    logic        w4_halted;
    logic [3:0]  w4_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] tv_inst [11] = '{16'hC100, 16'h1104, 16'hA000, 16'h8305, 16'hBD00, 16'hC2C0,
                                  16'hC385, 16'h5A00, 16'hC1D0, 16'hC150, 16'hC170};
    logic [22:0] tv_exp  [11] = '{23'h502381, 23'h416B82, 23'h418600, 23'h4123B3, 23'h418685,
                                  23'h4543E2, 23'h5923C3, 23'h411382, 23'h4303E9, 23'h5003A9,
                                  23'h4103B9};

    ctl_pipe #(.STAGES(3), .CNT_W(16)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .stall       (stall),
        .flush       (flush),
        .ctl_bus     (bus),
        .fetch_en    (fetch_en),
        .halted      (halted),
        .retired_cnt (cnt)
    );

    ctl_pipe #(.STAGES(3), .CNT_W(4)) u_w4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .stall       (stall),
        .flush       (flush),
        .ctl_bus     (w4_bus),
        .fetch_en    (w4_fetch_en),
        .halted      (w4_halted),
        .retired_cnt (w4_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [22:0] stg(input int s);
        return bus[s*23 +: 23];
    endfunction

    task automatic check_stages(input string tag, input logic [22:0] e0,
                                input logic [22:0] e1, input logic [22:0] e2);
        check_eq({tag, "_s0"}, 32'(stg(0)), 32'(e0));
        check_eq({tag, "_s1"}, 32'(stg(1)), 32'(e1));
        check_eq({tag, "_s2"}, 32'(stg(2)), 32'(e2));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; inst_valid = 1'b0; inst = '0; stall = 1'b0; flush = 1'b0;
        tick(); tick();

        // reset state
        check_stages("rst", BUB, BUB, BUB);
        check_eq("rst_fetch", 32'(fetch_en), 32'd1);
        check_eq("rst_halted", 32'(halted), 32'd0);
        check_eq("rst_cnt", 32'(cnt), 32'd0);
        check_eq("rst_w4_bus_s2", 32'(w4_bus[68:46]), 32'(BUB));
        rst_n = 1'b1;

        // single ADD: latency through stages and retire
        inst = 16'hC100; inst_valid = 1'b1; #1;
        check_eq("add_fetch", 32'(fetch_en), 32'd1);
        tick(); inst_valid = 1'b0;
        check_stages("add_e1", ADD, BUB, BUB);
        tick(); check_stages("add_e2", BUB, ADD, BUB);
        tick(); check_stages("add_e3", BUB, BUB, ADD);
        check_eq("add_cnt_e3", 32'(cnt), 32'd0);
        tick();
        check_eq("add_cnt_e4", 32'(cnt), 32'd1);
        check_eq("add_w4_cnt", 32'(w4_cnt), 32'd1);

        // back-to-back decode vectors
        for (int i = 0; i < 11; i++) begin
            inst = tv_inst[i]; inst_valid = 1'b1;
            tick();
            check_eq("dec_s0", 32'(stg(0)), 32'(tv_exp[i]));
            if (i >= 2) check_eq("dec_s2", 32'(stg(2)), 32'(tv_exp[i-2]));
        end
        inst_valid = 1'b0;
        tick(); tick(); tick();
        check_eq("dec_cnt", 32'(cnt), 32'd12);

        // LD then stall for two cycles
        inst = 16'h1104; inst_valid = 1'b1;
        tick(); check_eq("ld_s0", 32'(stg(0)), 32'(LD));
        stall = 1'b1; #1;
        check_eq("stall_fetch", 32'(fetch_en), 32'd0);
        tick(); check_stages("stall1", LD, BUB, BUB);
        tick(); check_stages("stall2", LD, BUB, BUB);
        stall = 1'b0; inst_valid = 1'b0;
        tick(); check_stages("unstall", BUB, LD, BUB);
        tick(); tick();
        check_eq("ld_cnt", 32'(cnt), 32'd13);

        // flush kills B in stage 0 and the incoming LI
        inst = 16'hA000; inst_valid = 1'b1;
        tick(); check_eq("br_s0", 32'(stg(0)), 32'(BR));
        inst = 16'h8305; flush = 1'b1; #1;
        check_eq("flush_fetch", 32'(fetch_en), 32'd0);
        tick(); check_stages("flush", BUB, BUB, BUB);
        flush = 1'b0; inst_valid = 1'b0;
        tick(); tick(); tick();
        check_eq("flush_cnt", 32'(cnt), 32'd13);

        // HLT cancelled by flush returns to RUN
        inst = 16'hC0F0; inst_valid = 1'b1; #1;
        check_eq("hltc_fetch0", 32'(fetch_en), 32'd0);
        tick(); check_eq("hltc_s0", 32'(stg(0)), 32'(HLT));
        inst_valid = 1'b0; flush = 1'b1;
        tick(); flush = 1'b0; #1;
        check_stages("hltc_kill", BUB, BUB, BUB);
        check_eq("hltc_fetch1", 32'(fetch_en), 32'd1);
        check_eq("hltc_halted", 32'(halted), 32'd0);
        inst = 16'hC100; inst_valid = 1'b1;
        tick(); check_eq("hltc_run_s0", 32'(stg(0)), 32'(ADD));
        inst_valid = 1'b0;
        tick(); tick(); tick();
        check_eq("hltc_cnt", 32'(cnt), 32'd14);
        check_eq("hltc_halted2", 32'(halted), 32'd0);

        // HLT drains and halts; later instructions ignored
        inst = 16'hC0F0; inst_valid = 1'b1; #1;
        check_eq("hlt_fetch0", 32'(fetch_en), 32'd0);
        tick(); check_eq("hlt_s0", 32'(stg(0)), 32'(HLT));
        inst = 16'hC100; #1;
        check_eq("drain_fetch", 32'(fetch_en), 32'd0);
        tick(); check_stages("drain1", BUB, HLT, BUB);
        check_eq("drain1_halted", 32'(halted), 32'd0);
        tick(); check_stages("drain2", BUB, BUB, HLT);
        check_eq("drain2_halted", 32'(halted), 32'd0);
        check_eq("drain2_cnt", 32'(cnt), 32'd14);
        tick();
        check_eq("halted", 32'(halted), 32'd1);
        check_eq("halted_w4", 32'(w4_halted), 32'd1);
        check_eq("halted_cnt", 32'(cnt), 32'd15);
        check_stages("halted_bus", BUB, BUB, BUB);
        check_eq("halted_fetch", 32'(fetch_en), 32'd0);
        tick(); tick();
        check_stages("halted_ign", BUB, BUB, BUB);
        check_eq("halted_sticky", 32'(halted), 32'd1);
        check_eq("halted_cnt2", 32'(cnt), 32'd15);
        check_eq("halted_w4_fetch", 32'(w4_fetch_en), 32'd0);

        // reset exits HALTED; 17 ADDs wrap the 4-bit counter
        rst_n = 1'b0; inst_valid = 1'b0;
        tick(); rst_n = 1'b1;
        check_eq("rst2_halted", 32'(halted), 32'd0);
        check_eq("rst2_cnt", 32'(cnt), 32'd0);
        check_eq("rst2_w4_cnt", 32'(w4_cnt), 32'd0);
        check_eq("rst2_fetch", 32'(fetch_en), 32'd1);
        for (int i = 0; i < 17; i++) begin
            inst = 16'hC100; inst_valid = 1'b1;
            tick();
        end
        inst_valid = 1'b0;
        tick(); tick(); tick();
        check_eq("wrap_cnt16", 32'(cnt), 32'd17);
        check_eq("wrap_cnt4", 32'(w4_cnt), 32'd1);

        // reset mid-drain with stall and flush asserted
        inst = 16'hC100; inst_valid = 1'b1;
        tick();
        inst = 16'hC0F0;
        tick(); check_stages("pre_rst", HLT, ADD, BUB);
        rst_n = 1'b0; stall = 1'b1; flush = 1'b1;
        tick();
        stall = 1'b0; flush = 1'b0; inst_valid = 1'b0; #1;
        check_stages("mid_rst", BUB, BUB, BUB);
        check_eq("mid_rst_halted", 32'(halted), 32'd0);
        check_eq("mid_rst_cnt", 32'(cnt), 32'd0);
        check_eq("mid_rst_w4_cnt", 32'(w4_cnt), 32'd0);
        check_eq("mid_rst_fetch", 32'(fetch_en), 32'd1);
        rst_n = 1'b1;
        inst = 16'hC100; inst_valid = 1'b1;
        tick(); check_eq("post_rst_s0", 32'(stg(0)), 32'(ADD));
        inst_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
